// File: rtl/match_ctrl_if.sv
// match_ctrl_if -- bundle of the match sequencer's key/frame/miss inputs and
// its control/score outputs.
//   slave  : used by match_ctrl (inputs *_i, drives *_o)
//   master : used by whatever drives the sequencer (drives *_i, reads *_o)
// Signals:
//   keys_i [KEYS_W]   debounced keys, [1]=up [0]=down
//   new_frame_i       1-cycle pulse per video frame
//   miss_left_i       ball left on enemy side (player scores)
//   miss_right_i      ball left on player side (enemy scores)
//   state_o [3]       sequencer state encoding
//   ball_run_o, paddles_en_o, ball_reset_o, serve_dir_o
//   player_score_o, enemy_score_o [SCORE_W], game_over_o, winner_o
interface match_ctrl_if #(
  parameter int KEYS_W  = 2,
  parameter int SCORE_W = 4
);
  logic [KEYS_W-1:0]  keys_i;
  logic               new_frame_i;
  logic               miss_left_i;
  logic               miss_right_i;
  logic [2:0]         state_o;
  logic               ball_run_o;
  logic               paddles_en_o;
  logic               ball_reset_o;
  logic               serve_dir_o;
  logic [SCORE_W-1:0] player_score_o;
  logic [SCORE_W-1:0] enemy_score_o;
  logic               game_over_o;
  logic               winner_o;

  modport slave (
    input  keys_i, new_frame_i, miss_left_i, miss_right_i,
    output state_o, ball_run_o, paddles_en_o, ball_reset_o, serve_dir_o,
           player_score_o, enemy_score_o, game_over_o, winner_o
  );

  modport master (
    output keys_i, new_frame_i, miss_left_i, miss_right_i,
    input  state_o, ball_run_o, paddles_en_o, ball_reset_o, serve_dir_o,
           player_score_o, enemy_score_o, game_over_o, winner_o
  );
endinterface

// File: rtl/match_ctrl.sv
// match_ctrl -- pong match sequencer. Gates ball/paddle motion, requests
// ball re-centring, keeps both scores and detects the end of the game.
// Ports:
//   clk_i  system clock
//   rst_i  asynchronous reset, active-high
//   bus    match_ctrl_if.slave (keys, frame pulse, misses in; control,
//          scores, game-over/winner out). All outputs are registered.
// Optional feature: define MATCH_CTRL_PAUSE_EN to add a PAUSE state entered
// and left from PLAY by a rising edge of both keys held together.
//
// state | meaning
// IDLE  | waiting for any key press to start a match
// SERVE | ball held centred for SERVE_FRAMES frames, paddles live
// PLAY  | ball and paddles live, misses sampled
// POINT | one cycle: point awarded, decide SERVE or OVER
// OVER  | game ended, keys locked out for OVER_FRAMES frames
// PAUSE | play frozen (only with MATCH_CTRL_PAUSE_EN)
module match_ctrl #(
  parameter int KEYS_W       = 2,
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int OVER_FRAMES  = 180
) (
  input  logic         clk_i,
  input  logic         rst_i,
  match_ctrl_if.slave  bus
);
  localparam int CNT_MAX = (SERVE_FRAMES > OVER_FRAMES) ? SERVE_FRAMES : OVER_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4,
    S_PAUSE = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [KEYS_W-1:0]  keys_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] pscore_q, pscore_d, escore_q, escore_d;
  logic               scorer_q, scorer_d;     // 0 = player, 1 = enemy
  logic               serve_dir_q, serve_dir_d;
  logic               ball_run_q, paddles_en_q, ball_reset_q, game_over_q, winner_q;

  logic any_rise, pause_rise, serve_done, over_done;

  assign any_rise   = |(bus.keys_i & ~keys_q);
  assign serve_done = bus.new_frame_i && (cnt_q == CNT_W'(SERVE_FRAMES - 1));
  assign over_done  = (cnt_q == CNT_W'(OVER_FRAMES));

`ifdef MATCH_CTRL_PAUSE_EN
  logic both_q;
  assign pause_rise = (&bus.keys_i) & ~both_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) both_q <= 1'b0;
    else       both_q <= &bus.keys_i;
  end
`else
  assign pause_rise = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pscore_d    = pscore_q;
    escore_d    = escore_q;
    scorer_d    = scorer_q;
    serve_dir_d = serve_dir_q;
    case (state_q)
      S_IDLE: if (any_rise) begin
        state_d  = S_SERVE;
        pscore_d = '0;
        escore_d = '0;
      end
      S_SERVE: if (serve_done) state_d = S_PLAY;
      S_PLAY: begin
        if (pause_rise) begin
          state_d = S_PAUSE;
        end else if (bus.miss_left_i && bus.miss_right_i) begin
          state_d = S_SERVE;              // simultaneous miss: replay, no score
        end else if (bus.miss_left_i) begin
          state_d     = S_POINT;
          scorer_d    = 1'b0;
          serve_dir_d = 1'b1;             // loser (enemy) gets the serve
          if (pscore_q != WIN) pscore_d = pscore_q + SCORE_W'(1);
        end else if (bus.miss_right_i) begin
          state_d     = S_POINT;
          scorer_d    = 1'b1;
          serve_dir_d = 1'b0;
          if (escore_q != WIN) escore_d = escore_q + SCORE_W'(1);
        end
      end
      S_POINT: state_d = (((scorer_q ? escore_q : pscore_q)) == WIN) ? S_OVER : S_SERVE;
      S_OVER: if (over_done && any_rise) begin
        state_d  = S_IDLE;
        pscore_d = '0;
        escore_d = '0;
      end
`ifdef MATCH_CTRL_PAUSE_EN
      S_PAUSE: if (pause_rise) state_d = S_PLAY;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Frame counter restarts on every state change and stops at OVER_FRAMES.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)
      cnt_d = '0;
    else if (bus.new_frame_i && ((state_q == S_SERVE) || (state_q == S_OVER && !over_done)))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      keys_q       <= '0;
      cnt_q        <= '0;
      pscore_q     <= '0;
      escore_q     <= '0;
      scorer_q     <= 1'b0;
      serve_dir_q  <= 1'b0;
      ball_run_q   <= 1'b0;
      paddles_en_q <= 1'b0;
      ball_reset_q <= 1'b0;
      game_over_q  <= 1'b0;
      winner_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      keys_q       <= bus.keys_i;
      cnt_q        <= cnt_d;
      pscore_q     <= pscore_d;
      escore_q     <= escore_d;
      scorer_q     <= scorer_d;
      serve_dir_q  <= serve_dir_d;
      // Outputs follow the next state so they change on the transition edge.
      ball_run_q   <= (state_d == S_PLAY);
      paddles_en_q <= (state_d == S_SERVE) || (state_d == S_PLAY);
      ball_reset_q <= (state_d == S_SERVE) && (state_q != S_SERVE);
      game_over_q  <= (state_d == S_OVER);
      winner_q     <= (state_d == S_OVER) ? scorer_d : 1'b0;
    end
  end

  assign bus.state_o        = state_q;
  assign bus.ball_run_o     = ball_run_q;
  assign bus.paddles_en_o   = paddles_en_q;
  assign bus.ball_reset_o   = ball_reset_q;
  assign bus.serve_dir_o    = serve_dir_q;
  assign bus.player_score_o = pscore_q;
  assign bus.enemy_score_o  = escore_q;
  assign bus.game_over_o    = game_over_q;
  assign bus.winner_o       = winner_q;
endmodule

// File: tb/tb_match_ctrl.sv
// tb_match_ctrl -- scoreboard bench for match_ctrl. The stimulus pushes the
// expected output snapshot for every state change it provokes; the monitor
// pops one snapshot each time state_o changes and compares all outputs.
module tb_match_ctrl;
  typedef struct packed {
    logic [2:0] st;
    logic       run, pen, brst, sdir;
    logic [3:0] ps, es;
    logic       go, win;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  match_ctrl_if #(.KEYS_W(2), .SCORE_W(4)) bus ();

  match_ctrl #(
    .KEYS_W(2), .SCORE_W(4), .WIN_SCORE(7), .SERVE_FRAMES(60), .OVER_FRAMES(180)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic [3:0] m_ps = 0, m_es = 0;
  logic       m_dir = 0;

  function automatic exp_t mk(input logic [2:0] st, input logic run, pen, brst, sdir,
                              input logic [3:0] ps, es, input logic go, win);
    exp_t e;
    e = '{st: st, run: run, pen: pen, brst: brst, sdir: sdir, ps: ps, es: es, go: go, win: win};
    return e;
  endfunction

  // Monitor
  initial begin
    logic [2:0] prev_st;
    logic       prev_brst;
    exp_t       e, act;
    prev_st   = 3'b111;
    prev_brst = 1'b0;
    forever begin
      @(negedge clk);
      act = mk(bus.state_o, bus.ball_run_o, bus.paddles_en_o, bus.ball_reset_o, bus.serve_dir_o,
               bus.player_score_o, bus.enemy_score_o, bus.game_over_o, bus.winner_o);
      if (prev_brst) begin
        checks++;
        if (bus.ball_reset_o !== 1'b0) begin
          errors++;
          $display("FAIL ball_reset_width: ball_reset_o=%b, required 0 on second SERVE cycle", bus.ball_reset_o);
        end
      end
      if (bus.state_o !== prev_st) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_transition: state %0d -> %0d at %0t, none required", prev_st, bus.state_o, $time);
        end else begin
          e = sb.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL transition st=%0d: got %p, required %p", e.st, act, e);
          end
        end
      end
      prev_st   = bus.state_o;
      prev_brst = bus.ball_reset_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame();
    bus.new_frame_i = 1'b1; tick();
    bus.new_frame_i = 1'b0; tick();
  endtask

  task automatic press(input logic [1:0] k);
    bus.keys_i = k;    tick();
    bus.keys_i = 2'b00; tick();
  endtask

  task automatic pulse_miss(input logic l, input logic r);
    bus.miss_left_i = l; bus.miss_right_i = r; tick();
    bus.miss_left_i = 0; bus.miss_right_i = 0; tick();
  endtask

  // From the start of SERVE: 59 frames must not leave SERVE, the 60th must.
  task automatic serve_to_play();
    for (int i = 0; i < 59; i++) pulse_frame();
    sb.push_back(mk(3'd2, 1, 1, 0, m_dir, m_ps, m_es, 0, 0));
    pulse_frame();
  endtask

  task automatic score(input logic enemy);
    if (enemy) begin m_es++; m_dir = 1'b0; end
    else       begin m_ps++; m_dir = 1'b1; end
    sb.push_back(mk(3'd3, 0, 0, 0, m_dir, m_ps, m_es, 0, 0));
    if ((enemy ? m_es : m_ps) == 4'd7)
      sb.push_back(mk(3'd4, 0, 0, 0, m_dir, m_ps, m_es, 1, enemy));
    else
      sb.push_back(mk(3'd1, 0, 1, 1, m_dir, m_ps, m_es, 0, 0));
    pulse_miss(!enemy, enemy);
  endtask

  initial begin
    bus.keys_i = 2'b00; bus.new_frame_i = 0; bus.miss_left_i = 0; bus.miss_right_i = 0;
    sb.push_back(mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0));   // reset state
    tick(); tick(); tick();
    rst = 1'b0;
    tick();

    // Miss in IDLE ignored, then key[0] starts a match.
    pulse_miss(1, 0);
    sb.push_back(mk(3'd1, 0, 1, 1, 0, 0, 0, 0, 0));
    press(2'b01);
    serve_to_play();
    score(0);                            // 1:0, serve toward enemy
    pulse_miss(1, 0);                    // ignored in SERVE
    pulse_miss(0, 1);
    serve_to_play();
    sb.push_back(mk(3'd1, 0, 1, 1, m_dir, m_ps, m_es, 0, 0));
    pulse_miss(1, 1);                    // replay, no score change
    serve_to_play();
    score(1);                            // 1:1
    serve_to_play();
    score(0);                            // 2:1
    serve_to_play();
    score(0);                            // 3:1
    serve_to_play();
    score(1);                            // 3:2

    serve_to_play();
    tick(); tick();
    // Asynchronous reset mid-PLAY: visible at the following negedge.
    sb.push_back(mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0));
    m_ps = 0; m_es = 0; m_dir = 0;
    rst = 1'b1; tick(); tick();
    rst = 1'b0; tick();

    // Full game: player wins 7:0.
    sb.push_back(mk(3'd1, 0, 1, 1, 0, 0, 0, 0, 0));
    press(2'b10);
    for (int i = 0; i < 7; i++) begin
      serve_to_play();
      score(0);
    end
    press(2'b01);                        // locked out
    for (int i = 0; i < 179; i++) pulse_frame();
    press(2'b11);                        // still locked out (179 frames)
    pulse_frame();
    sb.push_back(mk(3'd0, 0, 0, 0, m_dir, 0, 0, 0, 0));
    m_ps = 0; m_es = 0;
    press(2'b01);

`ifdef MATCH_CTRL_PAUSE_EN
    sb.push_back(mk(3'd1, 0, 1, 1, m_dir, 0, 0, 0, 0));
    press(2'b01);
    serve_to_play();
    sb.push_back(mk(3'd5, 0, 0, 0, m_dir, 0, 0, 0, 0));
    press(2'b11);
    pulse_miss(1, 0);                    // ignored in PAUSE
    sb.push_back(mk(3'd2, 1, 1, 0, m_dir, 0, 0, 0, 0));
    press(2'b11);
`endif

    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_transitions: %0d expected transitions never seen, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
